// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stage encodings, opcode values and opcode classes
// used by the stage sequencer and the control unit.
package cpu_pkg;

   localparam logic [2:0] S_IF   = 3'b000;
   localparam logic [2:0] S_ID   = 3'b001;
   localparam logic [2:0] S_EX   = 3'b010;
   localparam logic [2:0] S_MEM  = 3'b011;
   localparam logic [2:0] S_WB   = 3'b100;
   localparam logic [2:0] S_HALT = 3'b101;

   localparam logic [5:0] OP_RT0  = 6'b000000;
   localparam logic [5:0] OP_RT1  = 6'b000001;
   localparam logic [5:0] OP_RT2  = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b000011;
   localparam logic [5:0] OP_ANDI = 6'b000100;
   localparam logic [5:0] OP_LW   = 6'b000101;
   localparam logic [5:0] OP_SW   = 6'b000111;
   localparam logic [5:0] OP_BLT  = 6'b001001;
   localparam logic [5:0] OP_BEQ  = 6'b001010;
   localparam logic [5:0] OP_BNE  = 6'b001011;
   localparam logic [5:0] OP_JMP  = 6'b001100;
   localparam logic [5:0] OP_CALL = 6'b001101;
   localparam logic [5:0] OP_RET  = 6'b001110;
   localparam logic [5:0] OP_PUSH = 6'b001111;
   localparam logic [5:0] OP_POP  = 6'b010000;

   typedef enum logic [2:0] {
      CLS_JMP = 3'd0,
      CLS_ALU = 3'd1,
      CLS_BR  = 3'd2,
      CLS_LD  = 3'd3,
      CLS_ST  = 3'd4,
      CLS_ILL = 3'd5
   } opcls_e;

endpackage

// File: rtl/stage_sequencer_if.sv
// Sequencer <-> core bundle: fetch/memory handshake, stage outputs and debug counters.
interface stage_sequencer_if #(parameter int CNT_W = 16);

   logic             run;
   logic [5:0]       opcode;
   logic             mem_ack;
   logic [2:0]       state;
   logic [2:0]       next_state;
   logic             mem_req;
   logic             ir_we;
   logic             instr_done;
   logic             halted;
   logic             err;
   logic [CNT_W-1:0] retired_cnt;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output run, opcode, mem_ack,
      input  state, next_state, mem_req, ir_we, instr_done, halted, err,
             retired_cnt, stall_cnt
   );

   modport slave (
      input  run, opcode, mem_ack,
      output state, next_state, mem_req, ir_we, instr_done, halted, err,
             retired_cnt, stall_cnt
   );

endinterface

// File: rtl/opclass_decode.sv
// Combinational opcode -> execution-class decoder, shared with the control unit.
module opclass_decode
   import cpu_pkg::*;
(
   input  logic [5:0] i_opcode,
   output opcls_e     o_cls
);

   // Map each legal opcode to its sequencing class; anything else is illegal.
   always_comb begin
      o_cls = CLS_ILL;
      case (i_opcode)
         OP_RT0, OP_RT1, OP_RT2, OP_ADDI, OP_ANDI: o_cls = CLS_ALU;
         OP_BLT, OP_BEQ, OP_BNE:                   o_cls = CLS_BR;
         OP_JMP, OP_CALL, OP_RET:                  o_cls = CLS_JMP;
         OP_LW, OP_POP:                            o_cls = CLS_LD;
         OP_SW, OP_PUSH:                           o_cls = CLS_ST;
         default:                                  o_cls = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB stage sequencer with memory handshake stalls,
// timeout/illegal-opcode halt and retired/stall debug counters.
module stage_sequencer
   import cpu_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   stage_sequencer_if.slave  bus
);

   logic [2:0]       r_state;
   logic [2:0]       w_next_state;
   opcls_e           w_cls;
   logic             w_mem_req;
   logic             w_wait;
   logic             w_to_hit;
   logic             w_ir_we;
   logic             w_done;
   logic [TO_W-1:0]  r_to_cnt;
   logic [CNT_W-1:0] r_retired_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             r_halted;
   logic             r_err;

   opclass_decode u_dec (
      .i_opcode (bus.opcode),
      .o_cls    (w_cls)
   );

   assign w_mem_req = ((r_state == S_IF) && bus.run) || (r_state == S_MEM);
   assign w_wait    = w_mem_req && !bus.mem_ack;
   // This wait cycle would be the MEM_TIMEOUT-th consecutive one.
   assign w_to_hit  = (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));

   // Next-stage selection and per-stage strobes.
   always_comb begin
      w_next_state = r_state;
      w_ir_we      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IF: begin
            if (bus.run && bus.mem_ack) begin
               w_ir_we      = 1'b1;
               w_next_state = S_ID;
            end else if (w_wait && w_to_hit) begin
               w_next_state = S_HALT;
            end else begin
               w_next_state = S_IF;
            end
         end
         S_ID: begin
            case (w_cls)
               CLS_JMP: begin
                  w_next_state = S_IF;
                  w_done       = 1'b1;
               end
               CLS_ALU, CLS_BR, CLS_LD, CLS_ST: w_next_state = S_EX;
               default:                         w_next_state = S_HALT;
            endcase
         end
         S_EX: begin
            case (w_cls)
               CLS_ALU: w_next_state = S_WB;
               CLS_BR: begin
                  w_next_state = S_IF;
                  w_done       = 1'b1;
               end
               CLS_LD, CLS_ST: w_next_state = S_MEM;
               default:        w_next_state = S_HALT;
            endcase
         end
         S_MEM: begin
            if (bus.mem_ack) begin
               case (w_cls)
                  CLS_LD: w_next_state = S_WB;
                  CLS_ST: begin
                     w_next_state = S_IF;
                     w_done       = 1'b1;
                  end
                  default: w_next_state = S_HALT;
               endcase
            end else if (w_to_hit) begin
               w_next_state = S_HALT;
            end else begin
               w_next_state = S_MEM;
            end
         end
         S_WB: begin
            w_next_state = S_IF;
            w_done       = 1'b1;
         end
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_HALT;
      endcase
   end

   // Stage register, halt/error flags, timeout and debug counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IF;
         r_halted      <= 1'b0;
         r_err         <= 1'b0;
         r_to_cnt      <= {TO_W{1'b0}};
         r_retired_cnt <= {CNT_W{1'b0}};
         r_stall_cnt   <= {CNT_W{1'b0}};
      end else begin
         r_state  <= w_next_state;
         r_halted <= (w_next_state == S_HALT);
         // Every entry into HALT is an error condition, so err simply latches it.
         r_err    <= r_err || (w_next_state == S_HALT);
         if (w_wait && (w_next_state == r_state)) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end else begin
            r_to_cnt <= {TO_W{1'b0}};
         end
         if (w_done) begin
            r_retired_cnt <= r_retired_cnt + CNT_W'(1);
         end
         if (w_wait && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.state       = r_state;
   assign bus.next_state  = w_next_state;
   assign bus.mem_req     = w_mem_req;
   assign bus.ir_we       = w_ir_we;
   assign bus.instr_done  = w_done;
   assign bus.halted      = r_halted;
   assign bus.err         = r_err;
   assign bus.retired_cnt = r_retired_cnt;
   assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer.
module tb_stage_sequencer;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   stage_sequencer_if #(.CNT_W(16)) bus ();

   stage_sequencer #(.CNT_W(16), .MEM_TIMEOUT(15), .TO_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] exp_st [9];
   logic       exp_dn [9];

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      bus.run = 1'b0;
      bus.mem_ack = 1'b0;
      bus.opcode = 6'b000000;
      #3;
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_retired", 32'(bus.retired_cnt), 32'd0);
      chk("rst_stall", 32'(bus.stall_cnt), 32'd0);

      // ALU op, zero wait: IF, ID, EX, WB
      rst_n = 1'b1;
      bus.run = 1'b1;
      bus.mem_ack = 1'b1;
      bus.opcode = 6'b000000;
      #1;
      chk("alu_if_state", 32'(bus.state), 32'd0);
      chk("alu_if_irwe", 32'(bus.ir_we), 32'd1);
      chk("alu_if_next", 32'(bus.next_state), 32'd1);
      step();
      chk("alu_id_state", 32'(bus.state), 32'd1);
      chk("alu_id_irwe", 32'(bus.ir_we), 32'd0);
      step();
      chk("alu_ex_state", 32'(bus.state), 32'd2);
      chk("alu_ex_next", 32'(bus.next_state), 32'd4);
      step();
      chk("alu_wb_state", 32'(bus.state), 32'd4);
      chk("alu_wb_done", 32'(bus.instr_done), 32'd1);
      step();
      chk("alu_ret_state", 32'(bus.state), 32'd0);
      chk("alu_retired", 32'(bus.retired_cnt), 32'd1);
      chk("alu_stall", 32'(bus.stall_cnt), 32'd0);

      // LW with three wait cycles in MEM
      bus.opcode = 6'b000101;
      step();
      step();
      chk("lw_ex_next", 32'(bus.next_state), 32'd3);
      step();
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus.mem_ack = 1'b1;
         #1;
         chk("lw_mem_hold", 32'(bus.state), 32'd3);
         chk("lw_mem_req", 32'(bus.mem_req), 32'd1);
         chk("lw_mem_next", 32'(bus.next_state), (i == 3) ? 32'd4 : 32'd3);
         step();
      end
      chk("lw_wb_state", 32'(bus.state), 32'd4);
      chk("lw_wb_done", 32'(bus.instr_done), 32'd1);
      chk("lw_stall", 32'(bus.stall_cnt), 32'd3);
      step();
      chk("lw_retired", 32'(bus.retired_cnt), 32'd2);

      // JMP, BEQ, SW back to back: 2 + 3 + 4 cycles, no WB
      exp_st = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3};
      exp_dn = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 9; i++) begin
         if (i == 0) bus.opcode = 6'b001100;
         if (i == 2) bus.opcode = 6'b001010;
         if (i == 5) bus.opcode = 6'b000111;
         #1;
         chk("seq_state", 32'(bus.state), 32'(exp_st[i]));
         chk("seq_done", 32'(bus.instr_done), 32'(exp_dn[i]));
         step();
      end
      chk("seq_back_if", 32'(bus.state), 32'd0);
      chk("seq_retired", 32'(bus.retired_cnt), 32'd5);

      // Illegal opcode halts without retiring
      bus.opcode = 6'b111111;
      step();
      chk("ill_id_next", 32'(bus.next_state), 32'd5);
      chk("ill_id_done", 32'(bus.instr_done), 32'd0);
      step();
      chk("ill_state", 32'(bus.state), 32'd5);
      chk("ill_halted", 32'(bus.halted), 32'd1);
      chk("ill_err", 32'(bus.err), 32'd1);
      for (int i = 0; i < 20; i++) begin
         chk("ill_mem_req", 32'(bus.mem_req), 32'd0);
         chk("ill_hold", 32'(bus.state), 32'd5);
         step();
      end
      chk("ill_retired", 32'(bus.retired_cnt), 32'd5);

      // Fetch timeout: no ack with run=1
      rst_n = 1'b0;
      #1;
      chk("rst2_state", 32'(bus.state), 32'd0);
      chk("rst2_err", 32'(bus.err), 32'd0);
      chk("rst2_retired", 32'(bus.retired_cnt), 32'd0);
      rst_n = 1'b1;
      bus.run = 1'b1;
      bus.mem_ack = 1'b0;
      bus.opcode = 6'b000000;
      #1;
      for (int i = 0; i < 15; i++) begin
         chk("to_wait_state", 32'(bus.state), 32'd0);
         chk("to_wait_next", 32'(bus.next_state), (i == 14) ? 32'd5 : 32'd0);
         step();
      end
      chk("to_state", 32'(bus.state), 32'd5);
      chk("to_err", 32'(bus.err), 32'd1);
      chk("to_stall", 32'(bus.stall_cnt), 32'd15);
      chk("to_mem_req", 32'(bus.mem_req), 32'd0);
      step();
      chk("to_stall_hold", 32'(bus.stall_cnt), 32'd15);

      // Asynchronous reset in the middle of a MEM stall
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      bus.run = 1'b1;
      bus.mem_ack = 1'b1;
      bus.opcode = 6'b000111;
      step();
      step();
      step();
      bus.mem_ack = 1'b0;
      step();
      step();
      chk("mid_mem_state", 32'(bus.state), 32'd3);
      chk("mid_mem_stall", 32'(bus.stall_cnt), 32'd2);
      rst_n = 1'b0;
      bus.run = 1'b0;
      #1;
      chk("arst_state", 32'(bus.state), 32'd0);
      chk("arst_stall", 32'(bus.stall_cnt), 32'd0);
      chk("arst_done", 32'(bus.instr_done), 32'd0);
      rst_n = 1'b1;
      bus.mem_ack = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("idle_state", 32'(bus.state), 32'd0);
         chk("idle_mem_req", 32'(bus.mem_req), 32'd0);
         chk("idle_irwe", 32'(bus.ir_we), 32'd0);
         step();
      end
      chk("idle_stall", 32'(bus.stall_cnt), 32'd0);
      chk("idle_retired", 32'(bus.retired_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
